rr_arbiter_4way16bit_chip: RTL and testbench

//   Four-channel 16-bit round-robin collector that sits directly upstream of mux_4way16bit_chip.

---
 rtl/rr_arbiter_4way16bit_chip.sv | 177 +++++++++++++++++
 tb/tb_rr_arbiter_4way16bit_chip.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_arbiter_4way16bit_chip.sv
// rr_arbiter_4way16bit_chip
//   Four-channel 16-bit round-robin collector feeding mux_4way16bit_chip.
//   Each channel has a one-word holding register. A full channel is granted
//   fairly, and the grant drives the mux select. The selected word is
//   presented on a valid/ready output port.
// Ports
//   clk, rst_n                      clock (rising edge), async active-low reset
//   {a,b,c,d}_data/_valid/_ready    per-channel input handshake; ready = slot empty
//   out_data                        mux output for hold[out_sel]
//   out_sel                         current grant, 00=a .. 11=d
//   out_valid/out_ready             output handshake
//
// mux_4way16bit_chip
//   Plain 4:1 16-bit multiplexer. s selects a/b/c/d.

module mux_4way16bit_chip (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic [15:0] c,
    input  logic [15:0] d,
    input  logic [1:0]  s,
    output logic [15:0] out
);

    always_comb begin
        out = a;
        case (s)
            2'd0:    out = a;
            2'd1:    out = b;
            2'd2:    out = c;
            default: out = d;
        endcase
    end

endmodule

module rr_arbiter_4way16bit_chip #(
    parameter int unsigned DATA_W   = 16,
    parameter logic [1:0]  INIT_PTR = 2'b11
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] a_data,
    input  logic              a_valid,
    output logic              a_ready,
    input  logic [DATA_W-1:0] b_data,
    input  logic              b_valid,
    output logic              b_ready,
    input  logic [DATA_W-1:0] c_data,
    input  logic              c_valid,
    output logic              c_ready,
    input  logic [DATA_W-1:0] d_data,
    input  logic              d_valid,
    output logic              d_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        out_sel,
    output logic              out_valid,
    input  logic              out_ready
);

    localparam int unsigned NCH = 4;
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] SEND = 1'b1;

    logic [0:0]        state, state_nxt;
    logic [1:0]        sel, sel_nxt;
    logic [1:0]        ptr, ptr_nxt;
    logic [NCH-1:0]    full, full_nxt;
    logic [NCH-1:0]    valid_vec;
    logic [NCH-1:0]    load;
    logic [DATA_W-1:0] data_vec [NCH];
    logic [DATA_W-1:0] hold [NCH];
    logic [2:0]        pick_idle;
    logic [2:0]        pick_send;

    // Round-robin search starting after 'last'; returns {found, index}.
    function automatic logic [2:0] rr_pick(input logic [NCH-1:0] req, input logic [1:0] last);
        logic [1:0] idx;
        logic [2:0] res;
        res = 3'b000;
        for (int i = 1; i <= 4; i++) begin
            idx = 2'(last + 2'(i));
            if (!res[2] && req[idx]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

    assign valid_vec   = {d_valid, c_valid, b_valid, a_valid};
    assign data_vec[0] = a_data;
    assign data_vec[1] = b_data;
    assign data_vec[2] = c_data;
    assign data_vec[3] = d_data;

    // Only empty slots accept, so a granted word never changes under the consumer.
    assign load = valid_vec & ~full;

    assign pick_idle = rr_pick(full, ptr);
    // The channel being drained is excluded; words loaded at this edge wait for the next pass.
    assign pick_send = rr_pick(full & ~(4'b0001 << sel), sel);

    assign a_ready   = ~full[0];
    assign b_ready   = ~full[1];
    assign c_ready   = ~full[2];
    assign d_ready   = ~full[3];
    assign out_sel   = sel;
    assign out_valid = (state == SEND);

    // Next-state and datapath control.
    always_comb begin
        state_nxt = state;
        sel_nxt   = sel;
        ptr_nxt   = ptr;
        full_nxt  = full | load;
        case (state)
            IDLE: begin
                if (pick_idle[2]) begin
                    sel_nxt   = pick_idle[1:0];
                    state_nxt = SEND;
                end
            end
            SEND: begin
                if (out_ready) begin
                    full_nxt[sel] = 1'b0;
                    ptr_nxt       = sel;
                    if (pick_send[2]) begin
                        sel_nxt = pick_send[1:0];
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Control registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            sel   <= 2'b00;
            ptr   <= INIT_PTR;
            full  <= '0;
        end else begin
            state <= state_nxt;
            sel   <= sel_nxt;
            ptr   <= ptr_nxt;
            full  <= full_nxt;
        end
    end

    // Holding registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NCH; i++) begin
                hold[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (load[i]) begin
                    hold[i] <= data_vec[i];
                end
            end
        end
    end

    mux_4way16bit_chip u_mux (
        .a   (hold[0]),
        .b   (hold[1]),
        .c   (hold[2]),
        .d   (hold[3]),
        .s   (sel),
        .out (out_data)
    );

endmodule

// File: tb/tb_rr_arbiter_4way16bit_chip.sv
// Testbench for rr_arbiter_4way16bit_chip: directed scenarios plus a random
// run checked against a channel-level reference model.

module tb_rr_arbiter_4way16bit_chip;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] dat [4];
    logic [3:0]  vld;
    logic [3:0]  rdy;
    logic        a_ready, b_ready, c_ready, d_ready;
    logic [15:0] out_data;
    logic [1:0]  out_sel;
    logic        out_valid;
    logic        out_ready;

    int total = 0;
    int bad   = 0;

    // Reference model state.
    bit          m_full [4];
    logic [15:0] m_hold [4];
    int          m_grant;
    int          m_last;

    always #5 clk = ~clk;

    assign rdy = {d_ready, c_ready, b_ready, a_ready};

    rr_arbiter_4way16bit_chip dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a_data    (dat[0]),
        .a_valid   (vld[0]),
        .a_ready   (a_ready),
        .b_data    (dat[1]),
        .b_valid   (vld[1]),
        .b_ready   (b_ready),
        .c_data    (dat[2]),
        .c_valid   (vld[2]),
        .c_ready   (c_ready),
        .d_data    (dat[3]),
        .d_valid   (vld[3]),
        .d_ready   (d_ready),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        vld       = 4'b0000;
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) dat[i] = 16'h0000;
    endtask

    task automatic do_reset();
        clear_inputs();
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // First pending channel strictly after 'after', in circular order; -1 if none.
    function automatic int next_pending(input bit pend [4], input int after);
        for (int k = 1; k <= 4; k++) begin
            if (pend[(after + k) % 4]) return (after + k) % 4;
        end
        return -1;
    endfunction

    task automatic test_reset();
        clear_inputs();
        rst_n = 1'b0;
        #1;
        total++;
        if (out_valid !== 1'b0 || out_sel !== 2'b00 || out_data !== 16'h0000 || rdy !== 4'b1111) begin
            bad++;
            $display("FAIL reset: valid=%b sel=%b data=%h ready=%b, want 0/00/0000/1111",
                     out_valid, out_sel, out_data, rdy);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        do_reset();
        dat[2] = 16'h0F0F; vld[2] = 1'b1; out_ready = 1'b1;
        tick();
        vld[2] = 1'b0;
        total++;
        if (c_ready !== 1'b0 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL single_accept: c_ready=%b valid=%b, want 0/0", c_ready, out_valid);
        end
        tick();
        total++;
        if (out_valid !== 1'b1 || out_sel !== 2'b10 || out_data !== 16'h0F0F) begin
            bad++;
            $display("FAIL single_grant: valid=%b sel=%b data=%h, want 1/10/0f0f", out_valid, out_sel, out_data);
        end
        tick();
        total++;
        if (out_valid !== 1'b0 || c_ready !== 1'b1) begin
            bad++;
            $display("FAIL single_release: valid=%b c_ready=%b, want 0/1", out_valid, c_ready);
        end
    endtask

    task automatic test_all_four();
        logic [15:0] words [4];
        words[0] = 16'h8001; words[1] = 16'h4002; words[2] = 16'h03E0; words[3] = 16'h00FF;
        do_reset();
        for (int i = 0; i < 4; i++) dat[i] = words[i];
        vld = 4'b1111; out_ready = 1'b1;
        tick();
        vld = 4'b0000;
        total++;
        if (rdy !== 4'b0000) begin
            bad++;
            $display("FAIL all_loaded: ready=%b, want 0000", rdy);
        end
        for (int k = 0; k < 4; k++) begin
            tick();
            total++;
            if (out_valid !== 1'b1 || out_sel !== 2'(k) || out_data !== words[k]) begin
                bad++;
                $display("FAIL all_grant%0d: valid=%b sel=%0d data=%h, want 1/%0d/%h",
                         k, out_valid, out_sel, out_data, k, words[k]);
            end
        end
        tick();
        total++;
        if (out_valid !== 1'b0 || rdy !== 4'b1111) begin
            bad++;
            $display("FAIL all_idle: valid=%b ready=%b, want 0/1111", out_valid, rdy);
        end
    endtask

    task automatic test_stall();
        do_reset();
        dat[1] = 16'h1234; vld[1] = 1'b1; out_ready = 1'b0;
        tick();
        vld[1] = 1'b0;
        tick();
        for (int k = 0; k < 5; k++) begin
            tick();
            total++;
            if (out_valid !== 1'b1 || out_sel !== 2'b01 || out_data !== 16'h1234 || b_ready !== 1'b0) begin
                bad++;
                $display("FAIL stall_hold%0d: valid=%b sel=%b data=%h b_ready=%b, want 1/01/1234/0",
                         k, out_valid, out_sel, out_data, b_ready);
            end
        end
        out_ready = 1'b1;
        tick();
        total++;
        if (out_valid !== 1'b0 || b_ready !== 1'b1) begin
            bad++;
            $display("FAIL stall_release: valid=%b b_ready=%b, want 0/1", out_valid, b_ready);
        end
        tick();
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL stall_once: valid=%b, want 0", out_valid);
        end
    endtask

    task automatic test_back_to_back();
        int prev = -1;
        int grants = 0;
        do_reset();
        dat[0] = 16'h1111; dat[1] = 16'h2222;
        vld = 4'b0011; out_ready = 1'b1;
        for (int k = 0; k < 24; k++) begin
            if (out_valid === 1'b1) begin
                total++;
                if ((prev == -1 && out_sel !== 2'b00) || (prev != -1 && int'(out_sel) == prev) ||
                    out_sel > 2'b01 || out_data !== ((out_sel == 2'b00) ? 16'h1111 : 16'h2222)) begin
                    bad++;
                    $display("FAIL b2b_grant%0d: sel=%0d data=%h prev=%0d, want alternating a/b",
                             grants, out_sel, out_data, prev);
                end
                prev = int'(out_sel);
                grants++;
            end
            tick();
        end
        vld = 4'b0000;
        total++;
        if (grants < 8) begin
            bad++;
            $display("FAIL b2b_count: grants=%0d, want >=8", grants);
        end
        tick(); tick(); tick();
    endtask

    task automatic test_reset_mid_send();
        do_reset();
        dat[0] = 16'hA5A5; dat[1] = 16'h5A5A;
        vld = 4'b0011; out_ready = 1'b1;
        tick();
        vld = 4'b0000;
        tick();
        tick();
        out_ready = 1'b0;
        total++;
        if (out_valid !== 1'b1 || out_sel !== 2'b01) begin
            bad++;
            $display("FAIL midrst_pre: valid=%b sel=%b, want 1/01", out_valid, out_sel);
        end
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (out_valid !== 1'b0 || rdy !== 4'b1111 || out_sel !== 2'b00) begin
            bad++;
            $display("FAIL midrst_async: valid=%b ready=%b sel=%b, want 0/1111/00", out_valid, rdy, out_sel);
        end
        @(negedge clk);
        rst_n = 1'b1;
        dat[0] = 16'h0A0A; dat[1] = 16'h0B0B;
        vld = 4'b0011; out_ready = 1'b1;
        tick();
        vld = 4'b0000;
        tick();
        total++;
        if (out_valid !== 1'b1 || out_sel !== 2'b00 || out_data !== 16'h0A0A) begin
            bad++;
            $display("FAIL midrst_first: valid=%b sel=%b data=%h, want 1/00/0a0a", out_valid, out_sel, out_data);
        end
        tick(); tick();
    endtask

    task automatic test_random();
        bit   pend [4];
        bit   loads [4];
        logic [3:0] exp_rdy;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            m_full[i] = 1'b0;
            m_hold[i] = 16'h0000;
        end
        m_grant = -1;
        m_last  = 3;
        for (int n = 0; n < 600; n++) begin
            for (int i = 0; i < 4; i++) begin
                vld[i] = ($urandom_range(0, 99) < 45);
                dat[i] = 16'($urandom);
            end
            out_ready = ($urandom_range(0, 99) < 60);
            // Model one clock edge using the values just driven.
            for (int i = 0; i < 4; i++) loads[i] = vld[i] && !m_full[i];
            if (m_grant >= 0) begin
                if (out_ready) begin
                    pend = m_full;
                    pend[m_grant] = 1'b0;
                    m_full[m_grant] = 1'b0;
                    m_last  = m_grant;
                    m_grant = next_pending(pend, m_last);
                end
            end else begin
                m_grant = next_pending(m_full, m_last);
            end
            for (int i = 0; i < 4; i++) begin
                if (loads[i]) begin
                    m_full[i] = 1'b1;
                    m_hold[i] = dat[i];
                end
            end
            tick();
            for (int i = 0; i < 4; i++) exp_rdy[i] = !m_full[i];
            total++;
            if (out_valid !== (m_grant >= 0) || rdy !== exp_rdy ||
                (m_grant >= 0 && (int'(out_sel) != m_grant || out_data !== m_hold[m_grant]))) begin
                bad++;
                $display("FAIL random_cyc%0d: valid=%b sel=%0d data=%h ready=%b, want valid=%0d sel=%0d data=%h ready=%b",
                         n, out_valid, out_sel, out_data, rdy, (m_grant >= 0), m_grant,
                         (m_grant >= 0) ? m_hold[m_grant] : 16'h0000, exp_rdy);
            end
        end
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_single();
        test_all_four();
        test_stall();
        test_back_to_back();
        test_reset_mid_send();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
